// File: rtl/guess_input_stage_pkg.sv
// Shared constants and types for the hangman front end.
// The letter codes and the FSM encoding are shared by the guess input
// stage, the hex display decoder and the word selector.
package guess_input_stage_pkg;

   localparam logic [5:0] LETTER_A    = 6'h0A;
   localparam logic [5:0] LETTER_Z    = 6'h23;
   localparam logic [5:0] DASH_CODE   = 6'h00;
   localparam int         NUM_LETTERS = 26;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      EVAL       = 2'd2,
      DB_RELEASE = 2'd3
   } db_state_t;

   // True when the code lies in the letter range A..Z.
   function automatic logic is_letter(input logic [5:0] code);
      return (code >= LETTER_A) && (code <= LETTER_Z);
   endfunction

endpackage

// File: rtl/guess_input_stage_button_debouncer.sv
// Button debouncer: 2-flop synchronizer followed by a stable-sample
// counter FSM. Emits one single-cycle press event per physical press.
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   key_n      raw active-low button, asynchronous and bouncy
//   press_evt  high for exactly one cycle (the EVAL cycle) per press
module button_debouncer
   import guess_input_stage_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic press_evt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q;
   logic             key_s;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   // Sync flops reset to 1 so a released button is seen out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q    <= 1'b1;
         key_s     <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         press_evt <= 1'b0;
      end else begin
         sync_q    <= key_n;
         key_s     <= sync_q;
         press_evt <= 1'b0;
         case (state)
            IDLE: begin
               if (!key_s) begin
                  state <= DB_PRESS;
                  cnt   <= '0;
               end
            end
            DB_PRESS: begin
               if (key_s) begin
                  state <= IDLE;
               end else if (cnt == LAST) begin
                  state     <= EVAL;
                  press_evt <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EVAL: begin
               state <= DB_RELEASE;
               cnt   <= '0;
            end
            DB_RELEASE: begin
               // Any low sample restarts the release window, so bounces on
               // release cannot produce a second event.
               if (!key_s) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/guess_input_stage.sv
// Guess input stage: debounces the guess key, samples the letter
// switches once per press, classifies the guess and keeps the per-game
// history of accepted letters.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   key_n            raw active-low guess button
//   guess_sw         letter code from switches
//   clear_history    new-game pulse; clears used_mask and guess_count
//   guess_new/dup/bad  mutually exclusive single-cycle result pulses
//   guess_code       code sampled at the last evaluation
//   used_mask        bit i = letter (0x0A+i) accepted this game
//   guess_count      number of distinct accepted letters
module guess_input_stage
   import guess_input_stage_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CODE_W          = 6,
   parameter int CNT_W           = 20
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   key_n,
   input  logic [CODE_W-1:0]      guess_sw,
   input  logic                   clear_history,
   output logic                   guess_new,
   output logic                   guess_dup,
   output logic                   guess_bad,
   output logic [CODE_W-1:0]      guess_code,
   output logic [NUM_LETTERS-1:0] used_mask,
   output logic [4:0]             guess_count
);

   logic       press_evt;
   logic       valid;
   logic [4:0] idx;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debouncer (
      .clk       (clk),
      .resetn    (resetn),
      .key_n     (key_n),
      .press_evt (press_evt)
   );

   assign valid = is_letter(guess_sw);
   // Only meaningful when valid; truncation is harmless otherwise.
   assign idx   = 5'(guess_sw - LETTER_A);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         guess_new   <= 1'b0;
         guess_dup   <= 1'b0;
         guess_bad   <= 1'b0;
         guess_code  <= '0;
         used_mask   <= '0;
         guess_count <= '0;
      end else begin
         guess_new <= 1'b0;
         guess_dup <= 1'b0;
         guess_bad <= 1'b0;
         if (press_evt) begin
            guess_code <= guess_sw;
         end
         // A clear coinciding with an evaluation wins: the code is still
         // captured but no pulse fires and the history ends empty.
         if (clear_history) begin
            used_mask   <= '0;
            guess_count <= '0;
         end else if (press_evt) begin
            if (!valid) begin
               guess_bad <= 1'b1;
            end else if (used_mask[idx]) begin
               guess_dup <= 1'b1;
            end else begin
               guess_new      <= 1'b1;
               used_mask[idx] <= 1'b1;
               if (guess_count != 5'(NUM_LETTERS)) begin
                  guess_count <= guess_count + 5'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_guess_input_stage.sv
module tb_guess_input_stage;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        key_n = 1'b1;
   logic [5:0]  guess_sw = 6'h00;
   logic        clear_history = 1'b0;
   logic        guess_new, guess_dup, guess_bad;
   logic [5:0]  guess_code;
   logic [25:0] used_mask;
   logic [4:0]  guess_count;

   guess_input_stage #(.DEBOUNCE_CYCLES(DC), .CODE_W(6), .CNT_W(20)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .key_n         (key_n),
      .guess_sw      (guess_sw),
      .clear_history (clear_history),
      .guess_new     (guess_new),
      .guess_dup     (guess_dup),
      .guess_bad     (guess_bad),
      .guess_code    (guess_code),
      .used_mask     (used_mask),
      .guess_count   (guess_count)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
   endtask

   // Behavioural model: key_s is key_n delayed two edges; a press fires
   // after DC+1 consecutive low key_s samples while armed, the result is
   // registered one edge later, and re-arming needs DC consecutive high
   // samples after that.
   bit          m_s1, m_s2, m_ks;
   int          m_low, m_high;
   bit          m_armed, m_eval_now;
   bit          m_new, m_dup, m_bad;
   logic [5:0]  m_code;
   logic [25:0] m_mask;
   int          m_count;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_s1 = 1; m_s2 = 1; m_low = 0; m_high = 0;
         m_armed = 1; m_eval_now = 0;
         m_new = 0; m_dup = 0; m_bad = 0;
         m_code = 0; m_mask = 0; m_count = 0;
      end else begin
         m_ks = m_s2; m_s2 = m_s1; m_s1 = key_n;
         m_new = 0; m_dup = 0; m_bad = 0;
         if (m_eval_now) begin
            m_eval_now = 0; m_armed = 0; m_high = 0;
            m_code = guess_sw;
            if (!clear_history) begin
               if (int'(guess_sw) < 10 || int'(guess_sw) > 35) m_bad = 1;
               else if (m_mask[int'(guess_sw) - 10]) m_dup = 1;
               else begin
                  m_mask[int'(guess_sw) - 10] = 1'b1;
                  m_count++;
                  m_new = 1;
               end
            end
         end else if (m_armed) begin
            m_low = m_ks ? 0 : m_low + 1;
            if (m_low == DC + 1) begin m_eval_now = 1; m_low = 0; end
         end else begin
            m_high = m_ks ? m_high + 1 : 0;
            if (m_high == DC) m_armed = 1;
         end
         if (clear_history) begin m_mask = 0; m_count = 0; end
      end
   end

   // Cycle compare plus pulse counters, sampled on the falling edge.
   int n_new = 0, n_dup = 0, n_bad = 0;
   always @(negedge clk) begin
      chk("cycle", {24'd0, guess_new, guess_dup, guess_bad, guess_code, used_mask, guess_count},
                   {24'd0, m_new, m_dup, m_bad, m_code, m_mask, 5'(m_count)});
      if (guess_new) n_new++;
      if (guess_dup) n_dup++;
      if (guess_bad) n_bad++;
   end

   int s_new, s_dup, s_bad;
   task automatic snap();
      s_new = n_new; s_dup = n_dup; s_bad = n_bad;
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic press(input logic [5:0] code);
      guess_sw = code; key_n = 0; step(10);
      key_n = 1; step(12);
   endtask

   int lat, ev, seen;

   initial begin
      step(3);
      chk("rst_code", guess_code, 0);
      chk("rst_mask", used_mask, 0);
      chk("rst_count", guess_count, 0);
      chk("rst_pulses", {guess_new, guess_dup, guess_bad}, 0);
      resetn = 1; step(3);

      // Clean press 0x1C with latency: capture edge + 2 sync + DC+1
      snap(); guess_sw = 6'h1C; key_n = 0; lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (guess_new && lat == 0) lat = i;
      end
      chk("latency", lat, 8);
      key_n = 1; step(12);
      chk("clean_new", n_new - s_new, 1);
      chk("clean_code", guess_code, 6'h1C);
      chk("clean_mask", used_mask, 26'h0040000);
      chk("clean_count", guess_count, 1);

      // Same letter again
      snap(); press(6'h1C);
      chk("dup_pulse", n_dup - s_dup, 1);
      chk("dup_no_new", n_new - s_new, 0);
      chk("dup_mask", used_mask, 26'h0040000);
      chk("dup_count", guess_count, 1);

      // Bouncy press of 0x0B
      snap(); guess_sw = 6'h0B;
      repeat (3) begin key_n = 0; step(2); key_n = 1; step(2); end
      chk("bounce_quiet", (n_new - s_new) + (n_dup - s_dup) + (n_bad - s_bad), 0);
      key_n = 0; step(10); key_n = 1; step(12);
      chk("bounce_new", n_new - s_new, 1);
      chk("bounce_mask", used_mask, 26'h0040002);
      chk("bounce_count", guess_count, 2);

      // Standalone clear
      clear_history = 1; step(); clear_history = 0; step();
      chk("clr_mask", used_mask, 0);
      chk("clr_count", guess_count, 0);
      chk("clr_code", guess_code, 6'h0B);

      // Out-of-range codes
      snap(); press(6'h05); press(6'h24); press(6'h3F);
      chk("bad_pulses", n_bad - s_bad, 3);
      chk("bad_no_new", n_new - s_new, 0);
      chk("bad_mask", used_mask, 0);
      chk("bad_code", guess_code, 6'h3F);

      // Accept A and Y, then clear coinciding with EVAL of 0x0D
      press(6'h0A); press(6'h22);
      chk("acc_mask", used_mask, 26'h1000001);
      chk("acc_count", guess_count, 2);
      snap(); guess_sw = 6'h0D; key_n = 0; ev = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (m_eval_now) begin ev = i; break; end
      end
      chk("eval_cycle", ev, 7);
      clear_history = 1; step(); clear_history = 0;
      step(4); key_n = 1; step(12);
      chk("clrev_pulses", (n_new - s_new) + (n_dup - s_dup) + (n_bad - s_bad), 0);
      chk("clrev_mask", used_mask, 0);
      chk("clrev_count", guess_count, 0);
      chk("clrev_code", guess_code, 6'h0D);

      // Reset during DB_PRESS
      press(6'h10);
      chk("pre_rst_count", guess_count, 1);
      guess_sw = 6'h11; key_n = 0; step(4);
      resetn = 0; #1;
      chk("rst_press_mask", used_mask, 0);
      chk("rst_press_count", guess_count, 0);
      chk("rst_press_code", guess_code, 0);
      key_n = 1; step(2); resetn = 1; snap(); step(20);
      chk("rst_press_quiet", (n_new - s_new) + (n_dup - s_dup) + (n_bad - s_bad), 0);

      // Reset during the pulse cycle
      press(6'h11);
      guess_sw = 6'h12; key_n = 0; seen = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (guess_new) begin seen = 1; break; end
      end
      chk("pulse_seen", seen, 1);
      resetn = 0; #1;
      chk("rst_pulse_new", guess_new, 0);
      chk("rst_pulse_mask", used_mask, 0);
      chk("rst_pulse_count", guess_count, 0);
      key_n = 1; step(3); resetn = 1; snap(); step(20);
      chk("rst_pulse_quiet", (n_new - s_new) + (n_dup - s_dup) + (n_bad - s_bad), 0);
      snap(); press(6'h12);
      chk("fresh_new", n_new - s_new, 1);
      chk("fresh_mask", used_mask, 26'h0000100);
      chk("fresh_count", guess_count, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
